// File: rtl/ir_pkg.sv
// ir_pkg: register map, FSM encoding and CTRL bit layout
// shared by the IR packet scheduler files.
package ir_pkg;

  localparam logic [7:0] CMD_OFS  = 8'd0;
  localparam logic [7:0] CTRL_OFS = 8'd1;
  localparam logic [7:0] STAT_OFS = 8'd2;
  localparam logic [7:0] PER_OFS  = 8'd3;

  localparam int CTRL_REP   = 0;
  localparam int CTRL_PRI   = 1;
  localparam int CTRL_BURST = 4;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    FIRE,
    GAP
  } state_e;

  function automatic logic [7:0] stat_pack(
    input logic [3:0] rem,
    input logic       btn,
    input logic       bus,
    input logic       busy
  );
    return {rem, 1'b0, btn, bus, busy};
  endfunction

endpackage

// File: rtl/ir_packet_scheduler_if.sv
// ir_packet_scheduler_if: microprocessor address/strobe bundle.
// The tristate data bus stays a plain inout on the top.
interface ir_packet_scheduler_if;

  logic [7:0] BUS_ADDR;
  logic       BUS_WE;

  modport master (
    output BUS_ADDR,
    output BUS_WE
  );

  modport slave (
    input BUS_ADDR,
    input BUS_WE
  );

endinterface

// File: rtl/ir_tick_gen.sv
// ir_tick_gen: free-running divider emitting a one-cycle tick
// every TICK_CYCLES clocks, restartable by a synchronous clear.
module ir_tick_gen #(
  parameter int TICK_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int W =
    (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

  logic [W-1:0] cnt_q;

  // Count up and wrap on the last cycle of each period.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/ir_packet_scheduler.sv
// ir_packet_scheduler: arbitrates bus and push-button commands
// and paces SEND_PACKET pulses to the IR transmitter.
module ir_packet_scheduler
  import ir_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR      = 8'h90,
  parameter int         TICK_CYCLES    = 1000000,
  parameter int         DEFAULT_PERIOD = 10
) (
  input  logic                 CLK,
  input  logic                 RESET,
  ir_packet_scheduler_if.slave bus,
  inout  wire  [7:0]           BUS_DATA,
  input  logic                 Switch,
  input  logic                 Switch_mode,
  input  logic [3:0]           Push_button,
  output logic [3:0]           COMMAND,
  output logic                 SEND_PACKET,
  output logic                 BUSY
);

  localparam logic [7:0] A_CMD  = BASE_ADDR + CMD_OFS;
  localparam logic [7:0] A_CTRL = BASE_ADDR + CTRL_OFS;
  localparam logic [7:0] A_STAT = BASE_ADDR + STAT_OFS;
  localparam logic [7:0] A_PER  = BASE_ADDR + PER_OFS;
  localparam logic [7:0] PER_RST = 8'(DEFAULT_PERIOD);

  state_e     state_q;
  logic [3:0] cmd_q;
  logic       send_q;
  logic       busy_q;
  logic [3:0] rem_q;
  logic       cont_q;
  logic [7:0] gap_per_q;
  logic [7:0] gap_cnt_q;

  logic [3:0] bus_cmd_q;
  logic       bus_pend_q;
  logic [3:0] btn_cmd_q;
  logic       btn_pend_q;
  logic [3:0] pb_q;

  logic       rep_q;
  logic       pri_q;
  logic [3:0] burst_q;
  logic [7:0] per_q;

  logic       rd_q;
  logic [7:0] rd_data_q;

  logic [7:0] din;
  logic       wr_cmd;
  logic       wr_ctrl;
  logic       wr_per;
  logic       rd_stat;
  logic       btn_evt;
  logic       pend_any;
  logic       arb_btn;
  logic       arb_bus;
  logic       tick;
  logic       tick_clr;

  assign din     = BUS_DATA;
  assign wr_cmd  = bus.BUS_WE && (bus.BUS_ADDR == A_CMD);
  assign wr_ctrl = bus.BUS_WE && (bus.BUS_ADDR == A_CTRL);
  assign wr_per  = bus.BUS_WE && (bus.BUS_ADDR == A_PER);
  assign rd_stat = !bus.BUS_WE && (bus.BUS_ADDR == A_STAT);

  assign btn_evt = Switch_mode
                && (Push_button != 4'h0)
                && (Push_button != pb_q);

  // Same-cycle requests count so a write reaches ARB next cycle.
  assign pend_any = bus_pend_q | btn_pend_q | wr_cmd | btn_evt;

  assign arb_btn = btn_pend_q && (!bus_pend_q || pri_q);
  assign arb_bus = bus_pend_q && !arb_btn;

  assign tick_clr = (state_q == FIRE);

  ir_tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  // Request capture; a new request beats the ARB clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus_cmd_q  <= '0;
      bus_pend_q <= 1'b0;
      btn_cmd_q  <= '0;
      btn_pend_q <= 1'b0;
      pb_q       <= '0;
    end else begin
      pb_q <= Push_button;
      if (wr_cmd) begin
        bus_cmd_q  <= din[3:0];
        bus_pend_q <= 1'b1;
      end else if (state_q == ARB && arb_bus) begin
        bus_pend_q <= 1'b0;
      end
      if (!Switch_mode) begin
        btn_pend_q <= 1'b0;
      end else if (btn_evt) begin
        btn_cmd_q  <= Push_button;
        btn_pend_q <= 1'b1;
      end else if (state_q == ARB && arb_btn) begin
        btn_pend_q <= 1'b0;
      end
    end
  end

  // CTRL and PERIOD registers; a zero period is stored as 1.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rep_q   <= 1'b0;
      pri_q   <= 1'b0;
      burst_q <= '0;
      per_q   <= PER_RST;
    end else begin
      if (wr_ctrl) begin
        rep_q   <= din[CTRL_REP];
        pri_q   <= din[CTRL_PRI];
        burst_q <= din[CTRL_BURST +: 4];
      end
      if (wr_per) begin
        per_q <= (din == 8'd0) ? 8'd1 : din;
      end
    end
  end

  // Status read: sample at the address cycle, drive the next.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_q      <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_q <= rd_stat;
      if (rd_stat) begin
        rd_data_q <= stat_pack(rem_q, btn_pend_q,
                               bus_pend_q, busy_q);
      end
    end
  end

  assign BUS_DATA = rd_q ? rd_data_q : 8'hzz;

  // Sequencer FSM with registered COMMAND/SEND_PACKET/BUSY.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      send_q    <= 1'b0;
      busy_q    <= 1'b0;
      rem_q     <= '0;
      cont_q    <= 1'b0;
      gap_per_q <= 8'd1;
      gap_cnt_q <= '0;
    end else begin
      send_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Switch && pend_any) begin
            state_q <= ARB;
            busy_q  <= 1'b1;
          end
        end
        ARB: begin
          if (!bus_pend_q && !btn_pend_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cmd_q   <= arb_btn ? btn_cmd_q : bus_cmd_q;
            rem_q   <= rep_q ? burst_q : 4'd1;
            cont_q  <= rep_q && (burst_q == 4'd0);
            state_q <= FIRE;
            send_q  <= 1'b1;
          end
        end
        FIRE: begin
          if (!cont_q && rem_q != 4'd0) begin
            rem_q <= rem_q - 4'd1;
          end
          gap_per_q <= per_q;
          gap_cnt_q <= '0;
          state_q   <= GAP;
        end
        GAP: begin
          if (tick) begin
            if (gap_cnt_q != gap_per_q - 8'd1) begin
              gap_cnt_q <= gap_cnt_q + 8'd1;
            end else if (Switch && pend_any) begin
              state_q <= ARB;
            end else if (Switch && rep_q
                         && (cont_q || rem_q != 4'd0)) begin
              state_q <= FIRE;
              send_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign COMMAND     = cmd_q;
  assign SEND_PACKET = send_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_ir_packet_scheduler.sv
// tb_ir_packet_scheduler: scoreboard bench; expected pulses are
// queued from schedule arithmetic, a monitor pops per pulse.
module tb_ir_packet_scheduler;

  localparam int T = 4;
  localparam logic [7:0] A_CMD  = 8'h90;
  localparam logic [7:0] A_CTRL = 8'h91;
  localparam logic [7:0] A_STAT = 8'h92;
  localparam logic [7:0] A_PER  = 8'h93;

  typedef struct {
    int         cyc;
    logic [3:0] cmd;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       Switch = 1'b0;
  logic       Switch_mode = 1'b0;
  logic [3:0] Push_button = 4'h0;
  wire  [7:0] BUS_DATA;
  logic [3:0] COMMAND;
  logic       SEND_PACKET;
  logic       BUSY;
  logic       tb_oe = 1'b0;
  logic [7:0] tb_dout = 8'h00;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q[$];

  assign BUS_DATA = tb_oe ? tb_dout : 8'hzz;

  ir_packet_scheduler_if bus_if ();

  ir_packet_scheduler #(
    .BASE_ADDR      (8'h90),
    .TICK_CYCLES    (T),
    .DEFAULT_PERIOD (10)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .bus         (bus_if),
    .BUS_DATA    (BUS_DATA),
    .Switch      (Switch),
    .Switch_mode (Switch_mode),
    .Push_button (Push_button),
    .COMMAND     (COMMAND),
    .SEND_PACKET (SEND_PACKET),
    .BUSY        (BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(input bit ok, input string name,
                              input string act, input string req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, required %s", name, act, req);
  endfunction

  // Monitor: every pulse must match the head of the queue.
  always @(negedge CLK) begin
    exp_t e;
    bit   has;
    if (!RESET && SEND_PACKET) begin
      has = (q.size() > 0);
      if (has) e = q.pop_front();
      chk(has && e.cyc == cyc && e.cmd == COMMAND, "pulse",
          $sformatf("pulse@%0d cmd=%h", cyc, COMMAND),
          has ? $sformatf("pulse@%0d cmd=%h", e.cyc, e.cmd)
              : "no pulse");
    end
  end

  task automatic push(input int c, input logic [3:0] cm);
    exp_t e;
    e.cyc = c;
    e.cmd = cm;
    q.push_back(e);
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    bus_if.BUS_ADDR = a;
    bus_if.BUS_WE   = 1'b1;
    tb_dout         = d;
    tb_oe           = 1'b1;
    @(posedge CLK); #1;
    bus_if.BUS_WE   = 1'b0;
    tb_oe           = 1'b0;
    bus_if.BUS_ADDR = 8'h00;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
    bus_if.BUS_ADDR = a;
    bus_if.BUS_WE   = 1'b0;
    @(posedge CLK); #1;
    d = BUS_DATA;
    bus_if.BUS_ADDR = 8'h00;
    @(posedge CLK); #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic wait_idle(input int exp_c, input string name);
    int n = 0;
    while (BUSY && n < 600) begin
      @(posedge CLK); #1;
      n++;
    end
    chk(!BUSY && cyc == exp_c, name,
        $sformatf("busy=%0b idle@%0d", BUSY, cyc),
        $sformatf("idle@%0d", exp_c));
  endtask

  task automatic drained(input string name);
    chk(q.size() == 0, name,
        $sformatf("%0d pulses outstanding", q.size()), "0");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time exceeded, required finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic [3:0] c;
    logic [7:0] ctl;
    int d, s, n, iv, per;

    bus_if.BUS_ADDR = 8'h00;
    bus_if.BUS_WE   = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk(COMMAND == 4'h0, "reset_command",
        $sformatf("%h", COMMAND), "0");
    chk(SEND_PACKET == 1'b0, "reset_send",
        $sformatf("%b", SEND_PACKET), "0");
    chk(BUSY == 1'b0, "reset_busy", $sformatf("%b", BUSY), "0");
    RESET  = 1'b0;
    Switch = 1'b1;
    bus_rd(A_STAT, rd);
    chk(rd == 8'h00, "reset_status", $sformatf("%h", rd), "00");

    // One-shot at the default 10-tick period.
    bus_wr(A_CTRL, 8'h00);
    d = cyc;
    push(d + 2, 4'h5);
    bus_wr(A_CMD, 8'h05);
    wait_idle(d + 2 + 10 * T + 1, "oneshot_idle");
    drained("oneshot_drained");

    // Burst of 3, period 2, remaining visible in STATUS.
    bus_wr(A_PER, 8'd2);
    bus_wr(A_CTRL, 8'h31);
    d = cyc;
    for (int k = 0; k < 3; k++) push(d + 2 + k * (2 * T + 1), 4'hA);
    bus_wr(A_CMD, 8'h0A);
    for (int k = 0; k < 3; k++) begin
      wait_until(d + 2 + k * (2 * T + 1) + 3);
      bus_rd(A_STAT, rd);
      chk(rd == {4'(2 - k), 4'b0001}, "burst_status",
          $sformatf("%h", rd), $sformatf("%h", {4'(2 - k), 4'b0001}));
    end
    wait_idle(d + 2 + 3 * (2 * T + 1), "burst_idle");
    drained("burst_drained");

    // Randomized one-shot / burst traffic.
    for (int it = 0; it < 8; it++) begin
      int pw, rep, bn;
      pw  = $urandom_range(0, 3);
      per = (pw == 0) ? 1 : pw;
      rep = $urandom_range(0, 1);
      bn  = $urandom_range(1, 3);
      c   = 4'($urandom_range(1, 15));
      ctl = {4'(bn), 2'b00, 1'($urandom_range(0, 1)), 1'(rep)};
      n   = (rep != 0) ? bn : 1;
      iv  = per * T + 1;
      bus_wr(A_PER, 8'(pw));
      bus_wr(A_CTRL, ctl);
      d = cyc;
      for (int k = 0; k < n; k++) push(d + 2 + k * iv, c);
      bus_wr(A_CMD, {4'($urandom_range(0, 15)), c});
      wait_idle(d + 2 + n * iv, "rand_idle");
      drained("rand_drained");
    end

    // Button and bus in the same cycle, button has priority.
    bus_wr(A_PER, 8'd2);
    bus_wr(A_CTRL, 8'h02);
    Switch_mode = 1'b1;
    d = cyc;
    push(d + 2, 4'h3);
    push(d + 2 + 2 * T + 2, 4'h6);
    Push_button = 4'h3;
    bus_wr(A_CMD, 8'h06);
    wait_idle(d + 2 + 2 * T + 2 + 2 * T + 1, "arb_idle");
    drained("arb_drained");
    Push_button = 4'h0;
    Switch_mode = 1'b0;

    // Continuous repeat, preempted mid-gap, then stopped.
    bus_wr(A_PER, 8'd1);
    bus_wr(A_CTRL, 8'h01);
    d = cyc;
    push(d + 2, 4'h2);
    push(d + 7, 4'h2);
    push(d + 13, 4'h9);
    push(d + 18, 4'h9);
    bus_wr(A_CMD, 8'h02);
    wait_until(d + 9);
    bus_wr(A_CMD, 8'h09);
    wait_until(d + 20);
    bus_wr(A_CTRL, 8'h00);
    wait_idle(d + 23, "cont_idle");
    drained("cont_drained");

    // Switch off holds the request pending.
    Switch = 1'b0;
    c = 4'($urandom_range(1, 15));
    d = cyc;
    bus_wr(A_CMD, {4'h0, c});
    wait_until(d + 8);
    bus_rd(A_STAT, rd);
    chk(rd == 8'h02, "switch_off_status", $sformatf("%h", rd), "02");
    drained("switch_off_no_pulse");
    s = cyc;
    push(s + 2, c);
    Switch = 1'b1;
    wait_until(s + 1);
    wait_idle(s + 2 + T + 1, "switch_on_idle");
    drained("switch_on_drained");

    // Reset in the gap of a burst aborts it.
    bus_wr(A_PER, 8'd2);
    bus_wr(A_CTRL, 8'h31);
    c = 4'($urandom_range(1, 15));
    d = cyc;
    push(d + 2, c);
    bus_wr(A_CMD, {4'h0, c});
    wait_until(d + 5);
    RESET = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk(COMMAND == 4'h0, "midreset_command",
        $sformatf("%h", COMMAND), "0");
    chk(BUSY == 1'b0, "midreset_busy", $sformatf("%b", BUSY), "0");
    RESET = 1'b0;
    s = cyc;
    wait_until(s + 40);
    drained("midreset_no_pulse");
    bus_rd(A_STAT, rd);
    chk(rd == 8'h00, "midreset_status", $sformatf("%h", rd), "00");
    c = 4'($urandom_range(1, 15));
    d = cyc;
    push(d + 2, c);
    bus_wr(A_CMD, {4'h0, c});
    wait_idle(d + 2 + 10 * T + 1, "default_period_idle");
    drained("default_period_drained");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ir_packet_scheduler.md
Name: ir_packet_scheduler

Overview:
- Controller that sequences the IR transmitter state machine and shares it between two requesters: microprocessor bus writes and front-panel push buttons.
- Arbitrates pending commands, supports one-shot, burst and continuous repeat, and spaces packets by a programmable period.
- Drives the transmitter's COMMAND and SEND_PACKET inputs directly, replacing the free-running 10 Hz pulse counter.
- Exposes a bus-mapped control/status register window.

Parameters:
- BASE_ADDR, 8'h90, first of four bus register addresses (BASE_ADDR+0..+3).
- TICK_CYCLES, 1000000, CLK cycles per 10 ms period tick (100 MHz CLK).
- DEFAULT_PERIOD, 10, period register reset value in ticks (10 ticks = 100 ms = 10 Hz).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- BUS_ADDR  in  8  microprocessor address bus.
- BUS_DATA  inout  8  microprocessor data bus; driven only during a status read.
- BUS_WE  in  1  bus write enable.
- Switch  in  1  global transmit enable.
- Switch_mode  in  1  1 = push-button requester enabled; 0 = buttons ignored.
- Push_button  in  4  button command value.
- COMMAND  out  4  command presented to the transmitter.
- SEND_PACKET  out  1  one-cycle start pulse to the transmitter.
- BUSY  out  1  high whenever FSM is not IDLE.

Behaviour:
- Reset: clock is CLK; reset is RESET, synchronous, active-high. Reset state: COMMAND=0, SEND_PACKET=0, BUSY=0, BUS_DATA released (Z), FSM=IDLE, pending flags clear, CTRL=0, PERIOD=DEFAULT_PERIOD, tick counter=0.
- RESET mid-packet aborts immediately; no further SEND_PACKET is issued.
- Registers:
  - +0 CMD (write): BUS_DATA[3:0] -> bus_cmd; sets bus_pend. A write while bus_pend=1 overwrites the command (last write wins).
  - +1 CTRL (write): [0] repeat_en, [1] btn_priority, [7:4] burst_n.
  - +2 STATUS (read): {remaining[3:0], 1'b0, btn_pend, bus_pend, BUSY}.
  - +3 PERIOD (write): gap in ticks; a write of 0 is stored as 1.
- Bus reads: address +2 with BUS_WE=0 -> BUS_DATA driven on the next cycle only, with the status sampled at the address cycle. Z otherwise.
- Button requester:
  - Push_button is registered, and compared against the previous registered value while Switch_mode=1.
  - A change to a nonzero value sets btn_pend and captures btn_cmd.
  - Switch_mode=0 clears btn_pend and suppresses capture.
- FSM states and transitions:
  - IDLE: if Switch=1 and any pend -> ARB.
  - ARB (1 cycle):
    - Both pending: btn_priority=1 selects button, else bus. The loser stays pending.
    - Winner's flag cleared; COMMAND <= winner command.
    - remaining <= burst_n if repeat_en, else 1 (burst_n=0 with repeat_en = continuous). Then -> FIRE.
  - FIRE (1 cycle): SEND_PACKET=1; if not continuous, remaining decrements. -> GAP.
  - GAP:
    - Count PERIOD ticks; tick counter restarts on GAP entry.
    - First gap starts the cycle after the pulse.
    - At gap end: any pend with Switch=1 -> ARB (new request preempts repeat).
    - Else continuous, or remaining!=0, with Switch=1 and repeat_en=1 -> FIRE (same COMMAND).
    - Else -> IDLE.
- Latency: bus write at cycle t with FSM IDLE -> ARB at t+1 -> SEND_PACKET high at t+2.
- Minimum spacing between SEND_PACKET pulses = PERIOD*TICK_CYCLES+1 cycles. Pulses are never back-to-back.
- Switch low: GAP still runs to completion, then -> IDLE. Pending flags are retained.
- Clearing repeat_en during GAP stops after the current gap. PERIOD written during GAP takes effect at the next GAP entry.
- Bus write and button change in the same cycle both register, then arbitrate in ARB.
- remaining is 4-bit; it never wraps below 0, and the FSM exits at 0.
- COMMAND holds its last value in IDLE.

Decomposition:
- Shared package ir_pkg: register offsets (CMD_OFS=0, CTRL_OFS=1, STAT_OFS=2, PER_OFS=3), FSM state encoding (IDLE, ARB, FIRE, GAP), CTRL bit positions.
- One sub-module: ir_tick_gen. Free-running TICK_CYCLES divider with synchronous clear, emitting a 1-cycle tick; replaces the old 10 Hz counter.

Test Plan (TICK_CYCLES=4 in simulation):
- Reset, then write CMD=4'h5 at 8'h90 with CTRL=0, Switch=1 -> exactly one SEND_PACKET, 2 cycles after the write, COMMAND=5, BUSY falls after 10*4 cycles.
- CTRL=8'h31 (burst 3, repeat), PERIOD=2, CMD=4'hA -> three pulses 9 cycles apart, all COMMAND=A; STATUS read shows remaining 2, 1, 0 after each pulse.
- Switch_mode=1, same cycle: Push_button 0->4'h3 and bus CMD=4'h6, btn_priority=1 -> first packet COMMAND=3, second packet COMMAND=6 after the gap.
- Continuous repeat (CTRL=8'h01) with CMD=4'h2, then bus CMD=4'h9 mid-gap -> next pulse COMMAND=9; later write CTRL=0 -> pulses stop after the current gap.
- Switch=0 while pending -> no SEND_PACKET, bus_pend=1 in STATUS. Switch=1 -> pulse within 2 cycles.
- RESET asserted during GAP of a burst -> COMMAND=0, BUSY=0, and no further pulses; PERIOD reads back at default behaviour (10 ticks).
